leddc_frame_scheduler: RTL and testbench
========================================

Name: leddc_frame_scheduler

Overview:
- Frame-level sequencer for the LED display controller PWM datapath, on the GCK domain.
- Generates Vsync (blank/load vs. display windows) and the per-frame mode to the PWM/shift datapath.
- Manages the double-buffered pixel bank handshake with the frame writer: swaps banks only at frame boundaries, counts frames, and flags repeated or overrun frames.

Parameters:
- PWM_BITS, 16, grey-scale depth. Mode-0 display window is 2^PWM_BITS cycles; each mode-1 subframe is 2^(PWM_BITS-1) cycles.
- BLANK_CYCLES, 16, length of each Vsync-low blank/load window in GCK cycles. Legal range ≥2.
- FCNT_W, 16, width of the frame counter.

Ports:
- GCK  in  1  display clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled at frame end and in IDLE.
- mode_cfg  in  1  requested mode: 0 = single full frame, 1 = two half-weight subframes. Latched at frame start.
- load_done  in  1  one-cycle pulse from the writer: back bank fully written.
- Vsync  out  1  1 during display window, 0 during blank/idle.
- mode  out  1  latched mode for the current frame.
- sub_idx  out  1  current subframe (always 0 in mode 0).
- rd_bank  out  1  bank being displayed; the writer uses ~rd_bank.
- swap_ack  out  1  one-cycle pulse when a bank swap occurs.
- repeat_frame  out  1  one-cycle pulse when a frame starts without new data.
- ovf  out  1  sticky: load_done received while a swap was already pending.
- frame_cnt  out  FCNT_W  completed-frame counter.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - State = IDLE.
  - Vsync, mode, sub_idx, rd_bank, swap_ack, repeat_frame, ovf, busy = 0; frame_cnt = 0.
  - pending flag = 0; all counters = 0.
- pending flag:
  - Set by load_done.
  - Cleared by a swap.
  - If load_done and a swap occur in the same cycle, the load is consumed by that swap and pending ends at 0.
  - If load_done arrives while pending = 1 and no swap occurs that cycle, ovf is set and pending stays 1.
- All outputs are registered. Vsync == (state == DISPLAY), with no extra latency.
- States: IDLE, BLANK, DISPLAY.
- Frame start event:
  - Taken on IDLE→BLANK, or on DISPLAY→BLANK at frame end with enable = 1.
  - Actions, all in the same edge:
    - mode <= mode_cfg.
    - sub_idx <= 0.
    - If pending or load_done: rd_bank toggles, swap_ack pulses, pending cleared.
    - Otherwise: repeat_frame pulses (not possible from IDLE).
- IDLE:
  - Go to BLANK when enable = 1 and (pending or load_done).
  - Otherwise stay; enable alone without data does not start.
- BLANK:
  - Lasts exactly BLANK_CYCLES cycles with Vsync = 0, then goes to DISPLAY.
  - Counter reloads on every entry.
- DISPLAY:
  - Lasts L cycles with Vsync = 1.
  - L = 2^PWM_BITS when mode = 0; L = 2^(PWM_BITS-1) when mode = 1.
  - Counter width is PWM_BITS; terminal count is compared, not detected by overflow.
- End of DISPLAY:
  - mode = 1 and sub_idx = 0: sub_idx <= 1, go to BLANK. This is not a frame start: no swap, no mode relatch, frame_cnt unchanged.
  - Otherwise (frame end): frame_cnt increments, wrapping at 2^FCNT_W.
    - enable = 1: frame start event, go to BLANK.
    - enable = 0: go to IDLE; Vsync falls, mode and sub_idx hold.
- Changes to mode_cfg or enable mid-frame have no effect until the frame boundary. A frame in progress always completes.
- swap_ack and repeat_frame are never asserted in the same cycle, and each lasts exactly 1 cycle.

Test Plan (PWM_BITS=4, BLANK_CYCLES=4, FCNT_W=16):
- After rst, enable = 1, mode_cfg = 0, no load_done:
  - stays IDLE; Vsync = 0, busy = 0.
  - Then a load_done pulse: next edge gives swap_ack = 1, rd_bank = 1; Vsync low for 4 cycles, high for 16.
  - At frame end, frame_cnt = 1.
- Mode 1, continuous enable, one load_done per frame:
  - Vsync pattern per frame: 4 low, 8 high (sub_idx = 0), 4 low, 8 high (sub_idx = 1).
  - Exactly one swap_ack per frame, only at subframe-0 start.
- No load_done during the second frame:
  - repeat_frame pulses at the third frame start; rd_bank unchanged; frame_cnt still increments.
- Two load_done pulses within one frame:
  - ovf = 1 and stays 1 until rst.
  - A single swap occurs at the next frame start.
- load_done in the exact cycle of the frame-start edge:
  - swap occurs and pending = 0 afterwards.
  - A second load_done in the next frame does not set ovf.
- Edge cases:
  - Drop enable mid-DISPLAY: the frame completes, then IDLE.
  - Change mode_cfg mid-frame: it is applied only at the next frame.
  - Assert rst mid-DISPLAY: Vsync = 0 and frame_cnt = 0 immediately, before the next GCK edge.

Source files
------------

// File: rtl/leddc_frame_scheduler.sv
// ---------------------------------------------------------------------------
// leddc_frame_scheduler
//
// Frame-level sequencer for the LED display PWM datapath (GCK domain).
// Produces Vsync (blank/load vs. display windows), the per-frame mode and
// subframe index, and runs the double-buffered pixel bank handshake with the
// frame writer. Banks swap only at frame starts. Frames that start without
// new data are flagged with repeat_frame, and a second load that arrives
// before the first was consumed sets the sticky ovf flag.
//
// Ports
//   GCK          in   display clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   run request, sampled in IDLE and at frame end
//   mode_cfg     in   0 = one full frame, 1 = two half-weight subframes
//   load_done    in   one-cycle pulse: back bank fully written
//   Vsync        out  1 while in DISPLAY
//   mode         out  mode latched at frame start
//   sub_idx      out  current subframe (0 in mode 0)
//   rd_bank      out  bank on display; the writer owns ~rd_bank
//   swap_ack     out  one-cycle pulse on a bank swap
//   repeat_frame out  one-cycle pulse when a frame starts without new data
//   ovf          out  sticky load overrun
//   frame_cnt    out  completed-frame counter (wraps)
//   busy         out  state != IDLE
//   state_dbg    out  raw FSM state for observation
//
// Handshake: load_done is a single-cycle event. It is held in a pending
// flag until the next frame start consumes it with a swap; a load arriving
// on the frame-start edge itself is consumed directly by that swap.
// ---------------------------------------------------------------------------
module leddc_frame_scheduler #(
    parameter int PWM_BITS     = 16,
    parameter int BLANK_CYCLES = 16,
    parameter int FCNT_W       = 16
) (
    input  logic              GCK,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode_cfg,
    input  logic              load_done,
    output logic              Vsync,
    output logic              mode,
    output logic              sub_idx,
    output logic              rd_bank,
    output logic              swap_ack,
    output logic              repeat_frame,
    output logic              ovf,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BLANK   = 2'd1,
        S_DISPLAY = 2'd2
    } state_t;

    localparam int BW = $clog2(BLANK_CYCLES);
    localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK_CYCLES - 1);
    // Terminal counts of the display window, compared explicitly.
    localparam logic [PWM_BITS-1:0] TERM_FULL  = '1;
    localparam logic [PWM_BITS-1:0] TERM_HALF  =
        PWM_BITS'((64'd1 << (PWM_BITS - 1)) - 64'd1);

    state_t              state_q;
    logic [BW-1:0]       blank_cnt_q;
    logic [PWM_BITS-1:0] disp_cnt_q;
    logic                pending_q;
    logic                vsync_q;
    logic                mode_q;
    logic                sub_q;
    logic                bank_q;
    logic                swap_q;
    logic                repeat_q;
    logic                ovf_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                busy_q;

    logic blank_term;
    logic disp_term;
    logic sub_switch;
    logic frame_end;
    logic start_evt;
    logic swap_now;

    always_comb begin
        blank_term = (state_q == S_BLANK) && (blank_cnt_q == BLANK_LAST);
        disp_term  = (state_q == S_DISPLAY) &&
                     (disp_cnt_q == (mode_q ? TERM_HALF : TERM_FULL));
        // End of subframe 0 in mode 1 is a mid-frame blank, not a frame end.
        sub_switch = disp_term && mode_q && !sub_q;
        frame_end  = disp_term && !sub_switch;
        start_evt  = ((state_q == S_IDLE) && enable && (pending_q || load_done)) ||
                     (frame_end && enable);
        swap_now   = start_evt && (pending_q || load_done);
    end

    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blank_cnt_q <= '0;
            disp_cnt_q  <= '0;
            pending_q   <= 1'b0;
            vsync_q     <= 1'b0;
            mode_q      <= 1'b0;
            sub_q       <= 1'b0;
            bank_q      <= 1'b0;
            swap_q      <= 1'b0;
            repeat_q    <= 1'b0;
            ovf_q       <= 1'b0;
            fcnt_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            swap_q   <= 1'b0;
            repeat_q <= 1'b0;

            // A swap consumes both an older pending load and a same-cycle load.
            if (swap_now) begin
                pending_q <= 1'b0;
            end else if (load_done) begin
                if (pending_q) begin
                    ovf_q <= 1'b1;
                end
                pending_q <= 1'b1;
            end

            case (state_q)
                S_BLANK: begin
                    if (blank_term) begin
                        state_q    <= S_DISPLAY;
                        vsync_q    <= 1'b1;
                        disp_cnt_q <= '0;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + BW'(1);
                    end
                end
                S_DISPLAY: begin
                    if (sub_switch) begin
                        state_q     <= S_BLANK;
                        vsync_q     <= 1'b0;
                        sub_q       <= 1'b1;
                        blank_cnt_q <= '0;
                    end else if (frame_end) begin
                        fcnt_q  <= fcnt_q + FCNT_W'(1);
                        state_q <= S_IDLE;
                        vsync_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        disp_cnt_q <= disp_cnt_q + PWM_BITS'(1);
                    end
                end
                default: begin
                    // IDLE: leaving is handled entirely by the frame-start block.
                end
            endcase

            // Frame start overrides the idle/end transitions chosen above.
            if (start_evt) begin
                state_q     <= S_BLANK;
                vsync_q     <= 1'b0;
                busy_q      <= 1'b1;
                blank_cnt_q <= '0;
                mode_q      <= mode_cfg;
                sub_q       <= 1'b0;
                if (swap_now) begin
                    bank_q <= ~bank_q;
                    swap_q <= 1'b1;
                end else begin
                    repeat_q <= 1'b1;
                end
            end
        end
    end

    assign Vsync        = vsync_q;
    assign mode         = mode_q;
    assign sub_idx      = sub_q;
    assign rd_bank      = bank_q;
    assign swap_ack     = swap_q;
    assign repeat_frame = repeat_q;
    assign ovf          = ovf_q;
    assign frame_cnt    = fcnt_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_leddc_frame_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for leddc_frame_scheduler (PWM_BITS=4, BLANK_CYCLES=4, FCNT_W=16).
// The reference model views a running frame as a timeline position pos
// counted from the frame-start edge; window outputs are derived from pos
// with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_leddc_frame_scheduler;

    localparam int P  = 4;
    localparam int B  = 4;
    localparam int FW = 16;
    localparam int L  = 1 << P;
    localparam int H  = 1 << (P - 1);

    // ---------------- clock / reset ----------------
    logic          GCK = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          mode_cfg = 1'b0;
    logic          load_done = 1'b0;
    logic          Vsync, mode, sub_idx, rd_bank, swap_ack, repeat_frame, ovf, busy;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    state_dbg;

    always #5 GCK = ~GCK;

    leddc_frame_scheduler #(.PWM_BITS(P), .BLANK_CYCLES(B), .FCNT_W(FW)) dut (
        .GCK(GCK), .rst(rst), .enable(enable), .mode_cfg(mode_cfg),
        .load_done(load_done), .Vsync(Vsync), .mode(mode), .sub_idx(sub_idx),
        .rd_bank(rd_bank), .swap_ack(swap_ack), .repeat_frame(repeat_frame),
        .ovf(ovf), .frame_cnt(frame_cnt), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    bit          m_run, m_mode, m_sub, m_bank, m_pend, m_ovf, m_swap, m_rep;
    int          m_pos;
    logic [FW-1:0] m_fcnt;

    function automatic int frame_len(input bit md);
        return md ? 2 * (B + H) : (B + L);
    endfunction

    function automatic bit m_vs();
        if (!m_run) return 1'b0;
        if (m_mode) return ((m_pos >= B) && (m_pos < B + H)) || (m_pos >= 2 * B + H);
        return m_pos >= B;
    endfunction

    function automatic bit ends_next();
        return m_run && (m_pos + 1 == frame_len(m_mode));
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_sub = 0; m_bank = 0; m_pend = 0;
        m_ovf = 0; m_swap = 0; m_rep = 0; m_pos = 0; m_fcnt = '0;
    endtask

    task automatic model_step(input bit en, input bit mc, input bit ld);
        bit start;
        bit swp;
        start  = 0;
        m_swap = 0;
        m_rep  = 0;
        if (!m_run) begin
            start = en && (m_pend || ld);
        end else begin
            m_pos++;
            if (m_pos == frame_len(m_mode)) begin
                m_fcnt++;
                if (en) start = 1;
                else    m_run = 0;
            end
        end
        swp = start && (m_pend || ld);
        if (start) begin
            m_run  = 1;
            m_pos  = 0;
            m_mode = mc;
            if (swp) begin
                m_bank = ~m_bank;
                m_swap = 1;
            end else begin
                m_rep = 1;
            end
        end
        if (swp) begin
            m_pend = 0;
        end else if (ld) begin
            if (m_pend) m_ovf = 1;
            m_pend = 1;
        end
        if (m_run) m_sub = m_mode && (m_pos >= B + H);
    endtask

    function automatic logic [23:0] exp_vec();
        return {m_vs(), m_mode, m_sub, m_bank, m_swap, m_rep, m_ovf, m_run, m_fcnt};
    endfunction

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: one registered output vector per GCK edge.
    always begin
        @(posedge GCK);
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                chk("outputs{vs,md,sub,bank,swp,rep,ovf,busy,fcnt}",
                    {8'd0, Vsync, mode, sub_idx, rd_bank, swap_ack, repeat_frame,
                     ovf, busy, frame_cnt},
                    {8'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input bit en, input bit mc, input bit ld);
        enable    = en;
        mode_cfg  = mc;
        load_done = ld;
        model_step(en, mc, ld);
        exp_q.push_back(exp_vec());
    endtask

    task automatic step(input bit en, input bit mc, input bit ld);
        @(negedge GCK);
        apply(en, mc, ld);
    endtask

    task automatic release_reset(input bit en);
        @(negedge GCK);
        rst = 1'b0;
        model_reset();
        mon_en = 1;
        apply(en, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge GCK);
        #2;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int guard;
        model_reset();
        #3;
        chk("reset_vsync", {31'd0, Vsync}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rd_bank", {31'd0, rd_bank}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge GCK);
        release_reset(1'b1);

        // enable without data must not start
        repeat (8) step(1, 0, 0);
        after_edge();
        chk("idle_no_data_vsync", {31'd0, Vsync}, 32'd0);
        chk("idle_no_data_busy", {31'd0, busy}, 32'd0);

        // first load starts a mode-0 frame with a swap
        step(1, 0, 1);
        after_edge();
        chk("first_swap_ack", {31'd0, swap_ack}, 32'd1);
        chk("first_rd_bank", {31'd0, rd_bank}, 32'd1);
        repeat (B + L) step(1, 0, 0);
        after_edge();
        chk("first_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // mode 1, one load per frame
        for (int i = 0; i < 3 * frame_len(1) + frame_len(0); i++)
            step(1, 1, m_run && (m_pos == 5));

        // two frames without new data
        for (int i = 0; i < 2 * frame_len(1); i++) step(1, 1, 0);

        // load on the exact frame-start edge
        guard = 0;
        while (!ends_next() && guard < 100) begin
            step(1, 1, 0);
            guard++;
        end
        chk("reach_frame_end", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
        step(1, 1, 1);
        after_edge();
        chk("edge_load_swap_ack", {31'd0, swap_ack}, 32'd1);
        for (int i = 0; i < frame_len(1); i++) step(1, 0, m_pos == 6);
        after_edge();
        chk("edge_load_no_ovf", {31'd0, ovf}, 32'd0);

        // two loads inside one frame
        for (int i = 0; i < 2 * frame_len(1); i++)
            step(1, 0, m_run && ((m_pos == 3) || (m_pos == 9)));
        after_edge();
        chk("double_load_ovf", {31'd0, ovf}, 32'd1);

        // drop enable and change mode_cfg mid-frame: frame completes, then idle
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        for (int i = 0; i < 2 * frame_len(1); i++) step(0, 1'($urandom_range(0, 1)), 0);
        after_edge();
        chk("drop_enable_idle_busy", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // restart and reset asynchronously in the middle of DISPLAY
        guard = 0;
        do begin
            step(1, 0, guard == 0);
            guard++;
        end while (!(m_vs() && (m_pos > B + 2)) && guard < 100);
        chk("reach_display", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
        @(negedge GCK);
        mon_en = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vsync", {31'd0, Vsync}, 32'd0);
        chk("async_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("async_rst_ovf", {31'd0, ovf}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge GCK);
        release_reset(1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 11) == 0));
        step(0, 0, 0);
        after_edge();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
